// File: rtl/maxnet_winner_tracker_if.sv
// Maxnet winner tracker bus: alive-mask input channel, result output channel,
// and the status/debug taps that the controller and checkers observe.
//
// Both channels use strict valid/ready semantics: a transfer happens on a
// rising clk edge where valid and ready are both high; a source holds valid
// and its payload stable until that edge, and ready never depends
// combinationally on valid.
interface maxnet_winner_tracker_if #(
    parameter int N        = 4,
    parameter int MAX_ITER = 64
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(MAX_ITER + 1);

    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_alive;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [1:0]       out_status;
    logic [CNT_W-1:0] iter_count;
    logic             busy;
    logic [1:0]       state_dbg;

    // Controller side: issues start, masks, and accepts results.
    modport master (
        output start, in_valid, in_alive, out_ready,
        input  in_ready, out_valid, out_index, out_status, iter_count, busy, state_dbg
    );

    // Tracker side.
    modport slave (
        input  start, in_valid, in_alive, out_ready,
        output in_ready, out_valid, out_index, out_status, iter_count, busy, state_dbg
    );
endinterface

// File: rtl/maxnet_winner_tracker.sv
// Maxnet winner tracker: takes one per-channel alive mask per Maxnet
// iteration, counts iterations and reports the converged winner, total
// extinction, or an iteration timeout as a registered index/status pair.
//
// Optional build macro MAXNET_TIE_BREAK_EN: remember the previous evaluated
// mask so that a simultaneous extinction resolves toward the lowest channel
// that was still alive one iteration earlier.
module maxnet_winner_tracker #(
    parameter int N        = 4,
    parameter int MAX_ITER = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    maxnet_winner_tracker_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(MAX_ITER + 1);

    localparam logic [1:0] STAT_WINNER  = 2'b00;
    localparam logic [1:0] STAT_NONE    = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t           state;
    logic             out_valid_r;
    logic [IDX_W-1:0] out_index_r;
    logic [1:0]       out_status_r;
    logic [CNT_W-1:0] iter_count_r;

    logic             alive_none;
    logic             alive_one;
    logic [IDX_W-1:0] alive_low;
    logic [CNT_W-1:0] count_next;
    logic             count_at_max;
    logic [1:0]       none_status;
    logic [IDX_W-1:0] none_index;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Classify the offered mask and prepare the saturating next count.
    always_comb begin
        alive_none   = (bus.in_alive == '0);
        alive_one    = !alive_none && ((bus.in_alive & (bus.in_alive - N'(1))) == '0);
        alive_low    = lowest_set(bus.in_alive);
        count_next   = (iter_count_r == CNT_W'(MAX_ITER)) ? iter_count_r
                                                           : iter_count_r + CNT_W'(1);
        count_at_max = (count_next == CNT_W'(MAX_ITER));
    end

`ifdef MAXNET_TIE_BREAK_EN
    logic [N-1:0] prev_alive;

    // Track the last evaluated mask; a restart forgets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_alive <= '0;
        end else if (bus.start && state != ST_RESULT) begin
            prev_alive <= '0;
        end else if (state == ST_SCAN && bus.in_valid) begin
            prev_alive <= bus.in_alive;
        end
    end

    // Extinction falls back to the lowest survivor of the previous iteration.
    always_comb begin
        none_status = (prev_alive != '0) ? STAT_WINNER : STAT_NONE;
        none_index  = (prev_alive != '0) ? lowest_set(prev_alive) : '0;
    end
`else
    // Extinction is always reported as "none alive".
    always_comb begin
        none_status = STAT_NONE;
        none_index  = '0;
    end
`endif

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            out_valid_r  <= 1'b0;
            out_index_r  <= '0;
            out_status_r <= STAT_WINNER;
            iter_count_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state        <= ST_SCAN;
                        iter_count_r <= '0;
                    end
                end
                ST_SCAN: begin
                    if (bus.start) begin
                        // Restart wins over a same-cycle transfer, which is dropped.
                        iter_count_r <= '0;
                    end else if (bus.in_valid) begin
                        iter_count_r <= count_next;
                        if (alive_one) begin
                            state        <= ST_RESULT;
                            out_valid_r  <= 1'b1;
                            out_index_r  <= alive_low;
                            out_status_r <= STAT_WINNER;
                        end else if (alive_none) begin
                            state        <= ST_RESULT;
                            out_valid_r  <= 1'b1;
                            out_index_r  <= none_index;
                            out_status_r <= none_status;
                        end else if (count_at_max) begin
                            state        <= ST_RESULT;
                            out_valid_r  <= 1'b1;
                            out_index_r  <= alive_low;
                            out_status_r <= STAT_TIMEOUT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Handshake and status outputs decode straight from registers.
    always_comb begin
        bus.in_ready   = (state == ST_SCAN);
        bus.busy       = (state != ST_IDLE);
        bus.out_valid  = out_valid_r;
        bus.out_index  = out_index_r;
        bus.out_status = out_status_r;
        bus.iter_count = iter_count_r;
        bus.state_dbg  = state;
    end
endmodule

// File: tb/tb_maxnet_winner_tracker.sv
// Bench for maxnet_winner_tracker: one N=4/MAX_ITER=64 instance and one
// N=8/MAX_ITER=3 instance, directed steps followed by short random runs.
module tb_maxnet_winner_tracker;
    logic clk = 1'b0;
    logic rst_n;

    // Clock and reset.
    always #5 clk = ~clk;

    maxnet_winner_tracker_if #(.N(4), .MAX_ITER(64)) if_a ();
    maxnet_winner_tracker_if #(.N(8), .MAX_ITER(3))  if_b ();

    maxnet_winner_tracker #(.N(4), .MAX_ITER(64)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    maxnet_winner_tracker #(.N(8), .MAX_ITER(3))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard entry: {status[1:0], index[2:0], iter_count[6:0]}.
    logic [11:0] exp_q[$];

    int          m_count[2];
    logic [7:0]  m_prev[2];
    int          m_max[2] = '{64, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // DUT observation helpers.
    function automatic logic [11:0] result_of(input int inst);
        if (inst == 0) return {if_a.out_status, 1'b0, if_a.out_index, if_a.iter_count};
        else           return {if_b.out_status, if_b.out_index, 5'b0, if_b.iter_count};
    endfunction

    function automatic logic [6:0] count_of(input int inst);
        if (inst == 0) return if_a.iter_count;
        else           return {5'b0, if_b.iter_count};
    endfunction

    function automatic logic [2:0] flags_of(input int inst);
        if (inst == 0) return {if_a.out_valid, if_a.busy, if_a.in_ready};
        else           return {if_b.out_valid, if_b.busy, if_b.in_ready};
    endfunction

    // Driver tasks.
    task automatic set_start(input int inst, input logic v);
        if (inst == 0) if_a.start = v;
        else           if_b.start = v;
    endtask

    task automatic set_valid(input int inst, input logic v, input logic [7:0] m);
        if (inst == 0) begin
            if_a.in_valid = v;
            if_a.in_alive = m[3:0];
        end else begin
            if_b.in_valid = v;
            if_b.in_alive = m;
        end
    endtask

    task automatic set_ready(input int inst, input logic v);
        if (inst == 0) if_a.out_ready = v;
        else           if_b.out_ready = v;
    endtask

    function automatic int lowest8(input logic [7:0] v);
        int r;
        r = 0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Reference model of one accepted, evaluated mask.
    task automatic model_eval(input int inst, input logic [7:0] m, output bit decisive);
        int         cnt;
        int         p;
        int         idx;
        logic [1:0] st;
        cnt = (m_count[inst] < m_max[inst]) ? m_count[inst] + 1 : m_count[inst];
        m_count[inst] = cnt;
        p = $countones(m);
        decisive = 1'b1;
        st = 2'b00;
        idx = 0;
        if (p == 1) begin
            idx = lowest8(m);
        end else if (p == 0) begin
`ifdef MAXNET_TIE_BREAK_EN
            if (m_prev[inst] != 8'h00) idx = lowest8(m_prev[inst]);
            else                       st = 2'b01;
`else
            st = 2'b01;
`endif
        end else if (cnt == m_max[inst]) begin
            st  = 2'b10;
            idx = lowest8(m);
        end else begin
            decisive = 1'b0;
        end
        m_prev[inst] = m;
        if (decisive) exp_q.push_back({st, 3'(idx), 7'(cnt)});
    endtask

    task automatic pulse_start(input int inst);
        set_start(inst, 1'b1);
        cycle();
        set_start(inst, 1'b0);
        m_count[inst] = 0;
        m_prev[inst]  = 8'h00;
        check("start_flags", 32'(flags_of(inst)), 32'(3'b011));
        check("start_count", 32'(count_of(inst)), 32'd0);
    endtask

    task automatic send(input int inst, input logic [7:0] m, output bit decisive);
        set_valid(inst, 1'b1, m);
        check("in_ready", 32'(flags_of(inst)), 32'(3'b011));
        cycle();
        set_valid(inst, 1'b0, 8'h00);
        model_eval(inst, m, decisive);
    endtask

    // Pop the expected result, hold it under back-pressure, then hand it off.
    task automatic collect(input int inst, input int hold);
        logic [11:0] e;
        check("out_valid_latency", 32'(flags_of(inst)), 32'(3'b110));
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard: result present with empty expected queue");
            return;
        end
        e = exp_q.pop_front();
        check("result", 32'(result_of(inst)), 32'(e));
        for (int i = 0; i < hold; i++) begin
            cycle();
            check("hold_flags", 32'(flags_of(inst)), 32'(3'b110));
            check("hold_result", 32'(result_of(inst)), 32'(e));
        end
        set_ready(inst, 1'b1);
        cycle();
        set_ready(inst, 1'b0);
        check("handoff_flags", 32'(flags_of(inst)), 32'(3'b000));
        check("handoff_result_held", 32'(result_of(inst)), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          dec;
        logic [11:0] e;
        logic [7:0]  m;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_start(k, 1'b0);
            set_valid(k, 1'b0, 8'h00);
            set_ready(k, 1'b0);
            m_count[k] = 0;
            m_prev[k]  = 8'h00;
        end
        #3;
        check("reset_flags_a", 32'(flags_of(0)), 32'(3'b000));
        check("reset_result_a", 32'(result_of(0)), 32'd0);
        check("reset_flags_b", 32'(flags_of(1)), 32'(3'b000));
        check("reset_result_b", 32'(result_of(1)), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        // Asynchronous reset in the middle of a scan.
        pulse_start(0);
        for (int i = 0; i < 3; i++) send(0, 8'h0f, dec);
        check("scan_count_3", 32'(count_of(0)), 32'd3);
        rst_n = 1'b0;
        #2;
        check("midscan_reset_flags", 32'(flags_of(0)), 32'(3'b000));
        check("midscan_reset_count", 32'(count_of(0)), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_count[0] = 0;
        m_prev[0]  = 8'h00;
        cycle();

        // Convergence to a single winner with back-pressure.
        pulse_start(0);
        send(0, 8'h0f, dec);
        send(0, 8'h07, dec);
        send(0, 8'h04, dec);
        check("converge_const", 32'(result_of(0)), 32'({2'b00, 3'd2, 7'd3}));
        collect(0, 5);

        // Simultaneous extinction.
        pulse_start(0);
        send(0, 8'h06, dec);
        send(0, 8'h00, dec);
`ifdef MAXNET_TIE_BREAK_EN
        check("extinct_const", 32'(result_of(0)), 32'({2'b00, 3'd1, 7'd2}));
`else
        check("extinct_const", 32'(result_of(0)), 32'({2'b01, 3'd0, 7'd2}));
`endif
        collect(0, 1);

        // Timeout on the small-budget instance.
        pulse_start(1);
        for (int i = 0; i < 3; i++) send(1, 8'hc0, dec);
        check("timeout_const", 32'(result_of(1)), 32'({2'b10, 3'd6, 7'd3}));
        collect(1, 2);

        // Restart with a same-cycle transfer that must be dropped.
        pulse_start(0);
        send(0, 8'h0f, dec);
        send(0, 8'h0f, dec);
        set_start(0, 1'b1);
        set_valid(0, 1'b1, 8'h01);
        check("restart_in_ready", 32'(flags_of(0)), 32'(3'b011));
        cycle();
        set_start(0, 1'b0);
        set_valid(0, 1'b0, 8'h00);
        m_count[0] = 0;
        m_prev[0]  = 8'h00;
        check("restart_flags", 32'(flags_of(0)), 32'(3'b011));
        check("restart_count", 32'(count_of(0)), 32'd0);
        send(0, 8'h02, dec);
        check("restart_const", 32'(result_of(0)), 32'({2'b00, 3'd1, 7'd1}));
        collect(0, 0);

        // in_valid while idle is neither accepted nor counted.
        set_valid(0, 1'b1, 8'h01);
        check("idle_in_ready", 32'(flags_of(0)), 32'(3'b000));
        repeat (3) cycle();
        check("idle_flags", 32'(flags_of(0)), 32'(3'b000));
        check("idle_count_held", 32'(count_of(0)), 32'd1);
        set_valid(0, 1'b0, 8'h00);

        // start is ignored in RESULT, also on the handoff cycle.
        pulse_start(0);
        send(0, 8'h08, dec);
        set_start(0, 1'b1);
        cycle();
        set_start(0, 1'b0);
        check("result_start_flags", 32'(flags_of(0)), 32'(3'b110));
        e = exp_q.pop_front();
        check("result_start_value", 32'(result_of(0)), 32'(e));
        set_start(0, 1'b1);
        set_ready(0, 1'b1);
        cycle();
        set_start(0, 1'b0);
        set_ready(0, 1'b0);
        check("handoff_start_flags", 32'(flags_of(0)), 32'(3'b000));
        cycle();
        check("handoff_start_idle", 32'(flags_of(0)), 32'(3'b000));
        check("handoff_start_count", 32'(count_of(0)), 32'd1);

        // Random competitions on both instances.
        for (int r = 0; r < 6; r++) begin
            pulse_start(0);
            dec = 1'b0;
            for (int j = 0; j < 64 && !dec; j++) begin
                m = 8'($urandom_range(0, 15));
                send(0, m, dec);
            end
            collect(0, $urandom_range(0, 2));
        end
        for (int r = 0; r < 6; r++) begin
            pulse_start(1);
            dec = 1'b0;
            for (int j = 0; j < 3 && !dec; j++) begin
                m = 8'($urandom_range(0, 255));
                send(1, m, dec);
            end
            collect(1, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/maxnet_winner_tracker.md
Name: maxnet_winner_tracker

Overview:
Sequential, parametrised winner detector for the Maxnet datapath, generalised from the 4-input one-hot encoder to N channels. Accepts one per-channel "alive" mask per Maxnet iteration over a valid/ready handshake. Counts iterations and decides when the competition has converged: single winner, total extinction, or iteration timeout. Returns a registered index and status to the controller over a second valid/ready handshake.

Parameters:
N, 4, number of competing channels (>=1)
MAX_ITER, 64, iterations allowed before timeout (>=1)
Derived localparam IDX_W = max(1, clog2(N)); CNT_W = clog2(MAX_ITER+1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin (or restart) tracking a new competition
in_valid  in  1  in_alive carries one iteration's mask
in_ready  out  1  tracker accepts a mask this cycle
in_alive  in  N  bit i = 1 when channel i's value is still nonzero
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_index  out  IDX_W  winning channel index
out_status  out  2  00 winner, 01 none alive, 10 timeout, 11 unused
iter_count  out  CNT_W  iterations accepted since last start
busy  out  1  high in SCAN or RESULT

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, out_index=0, out_status=00, iter_count=0, busy=0, in_ready=0. Takes effect immediately, including mid-SCAN/RESULT; pending result discarded.
- States: IDLE, SCAN, RESULT. in_ready = (state==SCAN), decoded from state register only. busy = (state!=IDLE).
- IDLE: start=1 -> SCAN, iter_count<=0. Other inputs ignored.
- SCAN: transfer = in_valid & in_ready. Per transfer, with P = popcount(in_alive) and iter_count incremented:
  - P==1 -> RESULT, out_index = position of the set bit, status 00.
  - P==0 -> RESULT, status 01, out_index = 0 (see optional feature).
  - P>1 and new iter_count == MAX_ITER -> RESULT, status 10, out_index = lowest set bit index.
  - P>1 otherwise -> stay in SCAN.
- start=1 in SCAN: restart. iter_count<=0, stay SCAN. A transfer in the same cycle is accepted on the handshake but discarded (not counted, not evaluated).
- Latency: out_valid rises on the clock edge that accepts the decisive mask, so it is visible the next cycle. No bubbles between consecutive SCAN transfers; one transfer per cycle max.
- RESULT: out_valid=1. out_index, out_status and iter_count stay stable until out_valid & out_ready. On handshake -> IDLE, out_valid=0, busy=0. out_index/out_status/iter_count then hold their last values until the next start. start is ignored in RESULT, including on the handshake cycle.
- iter_count saturates at MAX_ITER. It never wraps.
- N=1: a mask of 1 is an immediate winner with index 0.
- MAX_ITER=1: first multi-alive mask yields timeout.

Optional Feature:
MAXNET_TIE_BREAK_EN. When defined, the tracker keeps a register prev_alive[N-1:0]. It is cleared to 0 on reset and on start, and loaded with each evaluated mask. On P==0 the result is status 00, out_index = lowest set bit of prev_alive, which resolves simultaneous extinction toward the lowest surviving channel. If prev_alive==0 (all-zero first mask), status 01 with index 0. When undefined, P==0 always gives status 01 with index 0, and no prev_alive register exists.

Test Plan:
- Reset: rst_n low mid-SCAN after 3 masks -> next observed cycle: out_valid=0, iter_count=0, busy=0, in_ready=0.
- Convergence: N=4, start, masks 1111, 0111, 0100 back-to-back -> out_valid one cycle after third transfer; index=2, status=00, iter_count=3. out_ready held low 5 cycles -> outputs stable.
- Extinction: N=4, masks 0110 then 0000. Without macro -> status 01, index 0. With MAXNET_TIE_BREAK_EN -> status 00, index 1.
- Timeout: N=8, MAX_ITER=3, masks 11000000 x3 -> status 10, index 6, iter_count=3.
- Restart: 2 masks accepted, then start asserted together with in_valid on mask 00000001 -> mask discarded, iter_count=0, still SCAN. Next mask 0010 -> index 1, iter_count=1.
- Back-pressure/idle: in_valid high in IDLE -> in_ready=0, nothing counted. start pulsed in RESULT -> ignored; after handshake returns to IDLE.
